buzzer_arbiter: RTL
===================

// Module: buzzer_arbiter
// PURPOSE
//  Shares the clock's single buzzer tone generator among three sound sources: key beep, hourly chime
//  and alarm melody. Latches requests, grants by fixed priority, steps each source's note sequence at
//  beat rate, and drives a note index (0 = rest, 1..21 = low/mid/high scale) to the tone divider.
// PARAMETERS
//  BEAT_DIV    25_000_000  sys_CLK cycles per beat (4 Hz at 100 MHz)
//  GAP_CYCLES  2_500_000   rest cycles at end of each beat (used only with BUZZ_ARB_GAP_EN)
// PORTS
//  sys_CLK     in   1  system clock; the only clock
//  rst_n       in   1  asynchronous, active-low reset
//  beep_req    in   1  1-cycle pulse: key beep request
//  chime_req   in   1  1-cycle pulse: hourly chime request
//  alarm_req   in   1  level: alarm active while high
//  alarm_stop  in   1  1-cycle pulse: stop alarm (snooze/dismiss)
//  note        out  5  note index to tone generator; 0 = silent
//  note_valid  out  1  tone generator enabled; note is 0 whenever note_valid is 0
//  grant       out  2  current owner: 00 none, 01 beep, 10 chime, 11 alarm
//  busy        out  1  grant != 00
//  done        out  1  1-cycle pulse: owner finished its sequence normally (not preempted/stopped)
// BEHAVIOUR
//  - Reset: note=0, note_valid=0, grant=00, busy=0, done=0; pending flags, beat counter, step cleared.
//  - beep_pend/chime_pend set by pulses; cleared when that source is granted or preempted. Pulses
//    from an already-owning source are ignored.
//  - Priority: alarm > chime > beep. FSM states IDLE, PLAY (plus GAP, see CONFIGURATION).
//  - IDLE: any pending/alarm_req seen on cycle N -> grant, busy, note_valid, first note registered at
//    N+1. Beat counter and step restart at 0 on every grant.
//  - PLAY: beat counter counts 0..BEAT_DIV-1; tick at BEAT_DIV-1. At tick: step+1; if last step,
//    source done -> done=1 for one cycle, then re-arbitrate on the same edge (next owner's note on
//    cycle after tick, no idle gap), else IDLE.
//  - Sequences (one entry per beat): beep {15}; chime {8,10,12,15}; alarm 8-step loop
//    {12,12,0,12,12,0,15,0}. Alarm entry 0 drives note=0, note_valid=0 (grant held).
//  - Alarm loops while alarm_req=1; ends at the tick after alarm_req=0 (done=1) or immediately on
//    alarm_stop (note_valid=0 next cycle, no done). alarm_stop ignored when alarm not granted.
//  - Preemption only at ticks: higher-priority source waiting at a tick takes over; preempted chime
//    or beep discarded (no done, pending not restored).
//  - Simultaneous beep+chime pulses: chime granted, beep stays pending, plays after chime.
//  - alarm_req high and alarm_stop same cycle: stop wins; alarm re-grants only after alarm_req falls
//    and rises again.
//  - Reset asserted mid-sequence: outputs to reset values asynchronously; nothing resumes.
//  - Step counter 3 bits, wraps 7->0 in alarm; beat counter width clog2(BEAT_DIV), never exceeds
//    BEAT_DIV-1.
// CONFIGURATION
//  BUZZ_ARB_GAP_EN defined: last GAP_CYCLES cycles of every beat enter GAP: note=0, note_valid=0,
//    grant held; tick still at BEAT_DIV-1 (beat length unchanged). Requires GAP_CYCLES < BEAT_DIV.
//  Undefined: no GAP state; consecutive equal notes play legato, note_valid continuous.
// TESTING (sim with BEAT_DIV=4, GAP_CYCLES=1)
//  1. beep_req pulse at idle -> next cycle grant=01, note=15 for 4 cycles, done pulse, grant=00.
//  2. chime_req+beep_req same cycle -> notes 8,10,12,15 (4 cycles each), done, then 15 from beep, done.
//  3. chime playing, alarm_req rises mid-beat 1 -> at tick note=12, grant=11; chime gives no done.
//  4. alarm_req held 20 beats -> pattern 12,12,0,12,12,0,15,0 repeats; drop -> ends at next tick, done=1.
//  5. alarm_stop during step 1 -> note_valid=0 next cycle, grant=00, no done; rst_n low mid-note -> all 0.
//  6. BUZZ_ARB_GAP_EN: beep -> note_valid high 3 cycles, low 1 cycle per beat; undefined -> high 4.

Source files
------------

// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: shares one buzzer tone generator among the key beep, the
// hourly chime and the alarm melody. Requests are latched, granted by fixed
// priority (alarm > chime > beep), and each owner's note sequence is stepped
// once per beat. All outputs are registered.
//
// Optional feature macro: BUZZ_ARB_GAP_EN
//   defined   : the last GAP_CYCLES cycles of every beat are silent (GAP
//               state), so repeated equal notes are articulated.
//   undefined : notes play legato and note_valid stays high across beats.
module buzzer_arbiter #(
    parameter int BEAT_DIV   = 25_000_000,
    parameter int GAP_CYCLES = 2_500_000
) (
    input  logic       sys_CLK,
    input  logic       rst_n,
    input  logic       beep_req,
    input  logic       chime_req,
    input  logic       alarm_req,
    input  logic       alarm_stop,
    output logic [4:0] note,
    output logic       note_valid,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_START = CNT_W'(BEAT_DIV - GAP_CYCLES);

`ifdef BUZZ_ARB_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Owner codes double as priority: a larger code outranks a smaller one.
    localparam logic [1:0] OWN_NONE  = 2'b00;
    localparam logic [1:0] OWN_BEEP  = 2'b01;
    localparam logic [1:0] OWN_CHIME = 2'b10;
    localparam logic [1:0] OWN_ALARM = 2'b11;

    // Note table: one entry per beat for each source.
    function automatic logic [4:0] seq_note(input logic [1:0] own, input logic [2:0] step);
        logic [4:0] n;
        case (own)
            OWN_BEEP:  n = 5'd15;
            OWN_CHIME: begin
                case (step[1:0])
                    2'd0:    n = 5'd8;
                    2'd1:    n = 5'd10;
                    2'd2:    n = 5'd12;
                    default: n = 5'd15;
                endcase
            end
            OWN_ALARM: begin
                case (step)
                    3'd0:    n = 5'd12;
                    3'd1:    n = 5'd12;
                    3'd2:    n = 5'd0;
                    3'd3:    n = 5'd12;
                    3'd4:    n = 5'd12;
                    3'd5:    n = 5'd0;
                    3'd6:    n = 5'd15;
                    default: n = 5'd0;
                endcase
            end
            default:   n = 5'd0;
        endcase
        return n;
    endfunction

    logic [1:0]       state_r, state_s;
    logic [1:0]       grant_r, grant_s;
    logic [2:0]       step_r, step_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             beep_pend_r, beep_pend_s;
    logic             chime_pend_r, chime_pend_s;
    logic             alarm_block_r, alarm_block_s;
    logic [4:0]       note_r, note_s;
    logic             note_valid_r, note_valid_s;
    logic             busy_r, done_r, done_s;

    logic             beep_want_s, chime_want_s, alarm_want_s;
    logic [1:0]       winner_s;
    logic             tick_s, stop_s, last_step_s, take_s;

    // Request qualification and fixed-priority winner; an owner's own pulses are dropped.
    always_comb begin
        beep_want_s  = beep_pend_r  | (beep_req  & (grant_r != OWN_BEEP));
        chime_want_s = chime_pend_r | (chime_req & (grant_r != OWN_CHIME));
        alarm_want_s = alarm_req & ~alarm_block_r;
        if (alarm_want_s) begin
            winner_s = OWN_ALARM;
        end else if (chime_want_s) begin
            winner_s = OWN_CHIME;
        end else if (beep_want_s) begin
            winner_s = OWN_BEEP;
        end else begin
            winner_s = OWN_NONE;
        end
    end

    // Beat tick, alarm stop and end-of-sequence detection for the current owner.
    always_comb begin
        tick_s = (state_r != ST_IDLE) && (cnt_r == BEAT_LAST);
        stop_s = alarm_stop && (grant_r == OWN_ALARM);
        case (grant_r)
            OWN_BEEP:  last_step_s = (step_r == 3'd0);
            OWN_CHIME: last_step_s = (step_r == 3'd3);
            OWN_ALARM: last_step_s = ~alarm_req;
            default:   last_step_s = 1'b1;
        endcase
    end

    // A stopped alarm stays locked out until alarm_req has been seen low.
    always_comb begin
        if (stop_s) begin
            alarm_block_s = 1'b1;
        end else if (!alarm_req) begin
            alarm_block_s = 1'b0;
        end else begin
            alarm_block_s = alarm_block_r;
        end
    end

    // Sequencer: grant, beat counting, stepping, completion and preemption at ticks.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        step_s       = step_r;
        cnt_s        = cnt_r;
        done_s       = 1'b0;
        take_s       = 1'b0;
        beep_pend_s  = beep_want_s;
        chime_pend_s = chime_want_s;
        case (state_r)
            ST_IDLE: begin
                take_s = (winner_s != OWN_NONE);
            end
            ST_PLAY, ST_GAP: begin
                if (stop_s) begin
                    state_s = ST_IDLE;
                    grant_s = OWN_NONE;
                    step_s  = 3'd0;
                    cnt_s   = '0;
                end else if (tick_s) begin
                    if (last_step_s) begin
                        done_s = 1'b1;
                        if (winner_s != OWN_NONE) begin
                            take_s = 1'b1;
                        end else begin
                            state_s = ST_IDLE;
                            grant_s = OWN_NONE;
                            step_s  = 3'd0;
                            cnt_s   = '0;
                        end
                    end else if (winner_s > grant_r) begin
                        // Preempted owner is simply dropped: no done, nothing re-queued.
                        take_s = 1'b1;
                    end else begin
                        step_s = step_r + 3'd1;
                        cnt_s  = '0;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = OWN_NONE;
                step_s  = 3'd0;
                cnt_s   = '0;
            end
        endcase

        if (take_s) begin
            state_s      = ST_PLAY;
            grant_s      = winner_s;
            step_s       = 3'd0;
            cnt_s        = '0;
            beep_pend_s  = beep_want_s  & (winner_s != OWN_BEEP);
            chime_pend_s = chime_want_s & (winner_s != OWN_CHIME);
        end else begin
            beep_pend_s  = beep_want_s;
            chime_pend_s = chime_want_s;
        end

        // Tail of each beat is silent when the gap feature is built in.
        if (state_s == ST_IDLE) begin
            state_s = ST_IDLE;
        end else if (GAP_EN && (cnt_s >= GAP_START)) begin
            state_s = ST_GAP;
        end else begin
            state_s = ST_PLAY;
        end
    end

    // Output decode from the next state so the registered note lines up with the grant.
    always_comb begin
        if (state_s == ST_PLAY) begin
            note_s = seq_note(grant_s, step_s);
        end else begin
            note_s = 5'd0;
        end
        note_valid_s = (note_s != 5'd0);
    end

    // State and output registers; reset forces silence and clears all pending work.
    always_ff @(posedge sys_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            grant_r       <= OWN_NONE;
            step_r        <= 3'd0;
            cnt_r         <= '0;
            beep_pend_r   <= 1'b0;
            chime_pend_r  <= 1'b0;
            alarm_block_r <= 1'b0;
            note_r        <= 5'd0;
            note_valid_r  <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            grant_r       <= grant_s;
            step_r        <= step_s;
            cnt_r         <= cnt_s;
            beep_pend_r   <= beep_pend_s;
            chime_pend_r  <= chime_pend_s;
            alarm_block_r <= alarm_block_s;
            note_r        <= note_s;
            note_valid_r  <= note_valid_s;
            busy_r        <= (grant_s != OWN_NONE);
            done_r        <= done_s;
        end
    end

    assign note       = note_r;
    assign note_valid = note_valid_r;
    assign grant      = grant_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
